unidade_controle_sequencia: RTL and testbench

UNIDADE_CONTROLE_SEQUENCIA -- requirements
Module: unidade_controle_sequencia

---
 rtl/unidade_controle_sequencia.sv | 161 ++++++++++++++++
 tb/tb_unidade_controle_sequencia.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/unidade_controle_sequencia.sv
// Sequence-game control unit: a Moore FSM that sequences counter clears and
// enables, the move register load, and the game-end status flags.
// Outputs are registered from the next state so they always match db_estado.
module unidade_controle_sequencia #(
    parameter bit TIMEOUT_EN = 1'b1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic       jogada,
    input  logic       igual,
    input  logic       fimE,
    input  logic       fimL,
    input  logic       fimT,
    output logic       zeraE,
    output logic       contaE,
    output logic       zeraL,
    output logic       contaL,
    output logic       zeraT,
    output logic       contaT,
    output logic       zeraR,
    output logic       registraR,
    output logic       pronto,
    output logic       acertou,
    output logic       errou,
    output logic       timeout,
    output logic [3:0] db_estado
);

    typedef enum logic [3:0] {
        Inicial          = 4'h0,
        Preparacao       = 4'h1,
        InicioSequencia  = 4'h2,
        EsperaJogada     = 4'h3,
        Registra         = 4'h4,
        Compara          = 4'h5,
        ProximaSequencia = 4'h6,
        ProximaJogada    = 4'h7,
        FimAcertou       = 4'hC,
        FimErrou         = 4'hD,
        FimTimeout       = 4'hE
    } estado_t;

    typedef struct packed {
        logic zera_e;
        logic conta_e;
        logic zera_l;
        logic conta_l;
        logic zera_t;
        logic conta_t;
        logic zera_r;
        logic registra_r;
        logic pronto;
        logic acertou;
        logic errou;
        logic timeout;
    } ctrl_t;

    estado_t estado_q, estado_d;
    ctrl_t   ctrl_q, ctrl_d;

    // Next-state logic; jogada is only looked at while waiting for a move.
    always_comb begin
        estado_d = estado_q;
        case (estado_q)
            Inicial:          if (iniciar) estado_d = Preparacao;
            Preparacao:       estado_d = InicioSequencia;
            InicioSequencia:  estado_d = EsperaJogada;
            EsperaJogada: begin
                // A move arriving together with the timeout end flag still wins.
                if (jogada) begin
                    estado_d = Registra;
                end else if (fimT && TIMEOUT_EN) begin
                    estado_d = FimTimeout;
                end
            end
            Registra:         estado_d = Compara;
            Compara: begin
                if (!igual) begin
                    estado_d = FimErrou;
                end else if (fimE && fimL) begin
                    estado_d = FimAcertou;
                end else if (fimE) begin
                    estado_d = ProximaSequencia;
                end else begin
                    estado_d = ProximaJogada;
                end
            end
            ProximaSequencia: estado_d = InicioSequencia;
            ProximaJogada:    estado_d = EsperaJogada;
            FimAcertou,
            FimErrou,
            FimTimeout:       if (iniciar) estado_d = Preparacao;
            default:          estado_d = Inicial;
        endcase
    end

    // Output decode of the state about to be entered, so the registered
    // outputs are a pure function of the current state.
    always_comb begin
        ctrl_d = '0;
        case (estado_d)
            Preparacao: begin
                ctrl_d.zera_e = 1'b1;
                ctrl_d.zera_l = 1'b1;
                ctrl_d.zera_r = 1'b1;
                ctrl_d.zera_t = 1'b1;
            end
            InicioSequencia: begin
                ctrl_d.zera_e = 1'b1;
                ctrl_d.zera_t = 1'b1;
            end
            EsperaJogada:     ctrl_d.conta_t = TIMEOUT_EN;
            Registra:         ctrl_d.registra_r = 1'b1;
            ProximaSequencia: ctrl_d.conta_l = 1'b1;
            ProximaJogada: begin
                ctrl_d.conta_e = 1'b1;
                ctrl_d.zera_t  = 1'b1;
            end
            FimAcertou: begin
                ctrl_d.pronto  = 1'b1;
                ctrl_d.acertou = 1'b1;
            end
            FimErrou: begin
                ctrl_d.pronto = 1'b1;
                ctrl_d.errou  = 1'b1;
            end
            FimTimeout: begin
                ctrl_d.pronto  = 1'b1;
                ctrl_d.timeout = 1'b1;
            end
            default:          ctrl_d = '0;
        endcase
    end

    // State and output registers; reset aborts any game immediately.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado_q <= Inicial;
            ctrl_q   <= '0;
        end else begin
            estado_q <= estado_d;
            ctrl_q   <= ctrl_d;
        end
    end

    assign zeraE     = ctrl_q.zera_e;
    assign contaE    = ctrl_q.conta_e;
    assign zeraL     = ctrl_q.zera_l;
    assign contaL    = ctrl_q.conta_l;
    assign zeraT     = ctrl_q.zera_t;
    assign contaT    = ctrl_q.conta_t;
    assign zeraR     = ctrl_q.zera_r;
    assign registraR = ctrl_q.registra_r;
    assign pronto    = ctrl_q.pronto;
    assign acertou   = ctrl_q.acertou;
    assign errou     = ctrl_q.errou;
    assign timeout   = ctrl_q.timeout;
    assign db_estado = estado_q;

endmodule

// File: tb/tb_unidade_controle_sequencia.sv
// Directed bench for unidade_controle_sequencia: one instance with the
// timeout exit enabled (a) and one with it disabled (b), sharing inputs.
module tb_unidade_controle_sequencia;

    logic clock = 1'b0;
    logic reset, iniciar, jogada, igual, fimE, fimL, fimT;

    logic zeraE_a, contaE_a, zeraL_a, contaL_a, zeraT_a, contaT_a;
    logic zeraR_a, registraR_a, pronto_a, acertou_a, errou_a, timeout_a;
    logic [3:0] db_a;
    logic zeraE_b, contaE_b, zeraL_b, contaL_b, zeraT_b, contaT_b;
    logic zeraR_b, registraR_b, pronto_b, acertou_b, errou_b, timeout_b;
    logic [3:0] db_b;

    // {zeraE,contaE,zeraL,contaL,zeraT,contaT,zeraR,registraR,pronto,acertou,errou,timeout}
    logic [11:0] out_a, out_b;
    assign out_a = {zeraE_a, contaE_a, zeraL_a, contaL_a, zeraT_a, contaT_a,
                    zeraR_a, registraR_a, pronto_a, acertou_a, errou_a, timeout_a};
    assign out_b = {zeraE_b, contaE_b, zeraL_b, contaL_b, zeraT_b, contaT_b,
                    zeraR_b, registraR_b, pronto_b, acertou_b, errou_b, timeout_b};

    logic [11:0] exp_a [16];
    logic [11:0] exp_b [16];

    int n_checks = 0;
    int n_errors = 0;

    unidade_controle_sequencia #(.TIMEOUT_EN(1'b1)) dut_a (
        .clock(clock), .reset(reset), .iniciar(iniciar), .jogada(jogada),
        .igual(igual), .fimE(fimE), .fimL(fimL), .fimT(fimT),
        .zeraE(zeraE_a), .contaE(contaE_a), .zeraL(zeraL_a), .contaL(contaL_a),
        .zeraT(zeraT_a), .contaT(contaT_a), .zeraR(zeraR_a), .registraR(registraR_a),
        .pronto(pronto_a), .acertou(acertou_a), .errou(errou_a), .timeout(timeout_a),
        .db_estado(db_a)
    );

    unidade_controle_sequencia #(.TIMEOUT_EN(1'b0)) dut_b (
        .clock(clock), .reset(reset), .iniciar(iniciar), .jogada(jogada),
        .igual(igual), .fimE(fimE), .fimL(fimL), .fimT(fimT),
        .zeraE(zeraE_b), .contaE(contaE_b), .zeraL(zeraL_b), .contaL(contaL_b),
        .zeraT(zeraT_b), .contaT(contaT_b), .zeraR(zeraR_b), .registraR(registraR_b),
        .pronto(pronto_b), .acertou(acertou_b), .errou(errou_b), .timeout(timeout_b),
        .db_estado(db_b)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Each vector: {iniciar,jogada,igual,fimE,fimL,fimT} applied, one edge, then
    // expected state of dut_a and dut_b; outputs come from the hand tables.
    task automatic run_table(input string name, input logic [13:0] v[$]);
        foreach (v[i]) begin
            {iniciar, jogada, igual, fimE, fimL, fimT} = v[i][13:8];
            step();
            n_checks++;
            if ({db_a, out_a} !== {v[i][7:4], exp_a[v[i][7:4]]}) begin
                n_errors++;
                $display("FAIL %s[%0d] en: got st=%h out=%h, expected st=%h out=%h",
                         name, i, db_a, out_a, v[i][7:4], exp_a[v[i][7:4]]);
            end
            n_checks++;
            if ({db_b, out_b} !== {v[i][3:0], exp_b[v[i][3:0]]}) begin
                n_errors++;
                $display("FAIL %s[%0d] dis: got st=%h out=%h, expected st=%h out=%h",
                         name, i, db_b, out_b, v[i][3:0], exp_b[v[i][3:0]]);
            end
        end
    endtask

    task automatic test_reset();
        logic [13:0] v[$];
        reset = 1'b1;
        {iniciar, jogada, igual, fimE, fimL, fimT} = 6'b100000;
        step();
        step();
        n_checks++;
        if ({db_a, out_a, db_b, out_b} !== 32'h0) begin
            n_errors++;
            $display("FAIL reset_hold: got a=%h/%h b=%h/%h, expected all zero",
                     db_a, out_a, db_b, out_b);
        end
        reset = 1'b0;
        v = '{{6'b100000, 4'h1, 4'h1}, {6'b000000, 4'h2, 4'h2}, {6'b000000, 4'h3, 4'h3}};
        run_table("reset_start", v);
    endtask

    task automatic test_proxima_jogada();
        logic [13:0] v[$];
        v = '{{6'b011000, 4'h4, 4'h4}, {6'b001000, 4'h5, 4'h5},
              {6'b001000, 4'h7, 4'h7}, {6'b001000, 4'h3, 4'h3}};
        run_table("proxima_jogada", v);
    endtask

    task automatic test_acerto();
        logic [13:0] v[$];
        v = '{{6'b011100, 4'h4, 4'h4}, {6'b001100, 4'h5, 4'h5},
              {6'b001100, 4'h6, 4'h6}, {6'b001100, 4'h2, 4'h2},
              {6'b001100, 4'h3, 4'h3}, {6'b011110, 4'h4, 4'h4},
              {6'b001110, 4'h5, 4'h5}, {6'b001110, 4'hC, 4'hC},
              {6'b010000, 4'hC, 4'hC}, {6'b000000, 4'hC, 4'hC},
              {6'b100000, 4'h1, 4'h1}, {6'b000000, 4'h2, 4'h2},
              {6'b000000, 4'h3, 4'h3}};
        run_table("acerto", v);
    endtask

    task automatic test_erro();
        logic [13:0] v[$];
        v = '{{6'b010000, 4'h4, 4'h4}, {6'b000000, 4'h5, 4'h5},
              {6'b000000, 4'hD, 4'hD}, {6'b010000, 4'hD, 4'hD},
              {6'b100000, 4'h1, 4'h1}, {6'b000000, 4'h2, 4'h2},
              {6'b000000, 4'h3, 4'h3}};
        run_table("erro", v);
    endtask

    task automatic test_timeout();
        logic [13:0] v[$];
        v = '{{6'b011001, 4'h4, 4'h4}, {6'b001000, 4'h5, 4'h5},
              {6'b001000, 4'h7, 4'h7}, {6'b000000, 4'h3, 4'h3},
              {6'b000001, 4'hE, 4'h3}, {6'b000001, 4'hE, 4'h3},
              {6'b100000, 4'h1, 4'h3}, {6'b000000, 4'h2, 4'h3},
              {6'b000000, 4'h3, 4'h3}};
        run_table("timeout", v);
    endtask

    task automatic test_reset_mid_compara();
        logic [13:0] v[$];
        v = '{{6'b011000, 4'h4, 4'h4}, {6'b001000, 4'h5, 4'h5}};
        run_table("pre_reset", v);
        #2;
        reset = 1'b1;
        #1;
        n_checks++;
        if ({db_a, out_a, db_b, out_b} !== 32'h0) begin
            n_errors++;
            $display("FAIL reset_async: got a=%h/%h b=%h/%h, expected all zero",
                     db_a, out_a, db_b, out_b);
        end
        iniciar = 1'b1;
        step();
        n_checks++;
        if ({db_a, out_a, db_b, out_b} !== 32'h0) begin
            n_errors++;
            $display("FAIL reset_ignores_iniciar: got a=%h/%h b=%h/%h, expected all zero",
                     db_a, out_a, db_b, out_b);
        end
        reset = 1'b0;
        v = '{{6'b100000, 4'h1, 4'h1}, {6'b000000, 4'h2, 4'h2}, {6'b000000, 4'h3, 4'h3}};
        run_table("post_reset", v);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            exp_a[i] = 12'h000;
            exp_b[i] = 12'h000;
        end
        exp_a[1]  = 12'hAA0; exp_b[1]  = 12'hAA0;
        exp_a[2]  = 12'h880; exp_b[2]  = 12'h880;
        exp_a[3]  = 12'h040; exp_b[3]  = 12'h000;
        exp_a[4]  = 12'h010; exp_b[4]  = 12'h010;
        exp_a[6]  = 12'h100; exp_b[6]  = 12'h100;
        exp_a[7]  = 12'h480; exp_b[7]  = 12'h480;
        exp_a[12] = 12'h00C; exp_b[12] = 12'h00C;
        exp_a[13] = 12'h00A; exp_b[13] = 12'h00A;
        exp_a[14] = 12'h009; exp_b[14] = 12'h009;

        test_reset();
        test_proxima_jogada();
        test_acerto();
        test_erro();
        test_timeout();
        test_reset_mid_compara();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
